// File: rtl/rv_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package rv_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_FORCE
    } arb_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_entry_t;

    localparam int unsigned FIFO_DEPTH_DEFAULT   = 2;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    // x0 is hardwired, so it never contributes a pending bit.
    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        logic [31:0] oh;
        oh = '0;
        if (rd != 5'd0) begin
            oh[rd] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rv_wb_fifo.sv
// Small synchronous FIFO of writeback entries; exposes per-entry valid/rd for hazard masking.
module rv_wb_fifo
    import rv_wb_arbiter_pkg::*;
#(
    parameter int unsigned Depth = FIFO_DEPTH_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  wb_entry_t                    entry_i,
    input  logic                         pop_i,
    output wb_entry_t                    head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic [Depth-1:0]             valid_o,
    output logic [Depth-1:0][4:0]        rd_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    wb_entry_t             mem_q [Depth];
    logic [PtrW-1:0]       wptr_q, wptr_d;
    logic [PtrW-1:0]       rptr_q, rptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [Depth-1:0]      valid_q, valid_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == CntW'(0));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
        // Push and pop never share a slot: push needs not-full, pop needs not-empty.
        if (push_ok) begin
            valid_d[wptr_q] = 1'b1;
            wptr_d          = wptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= entry_i;
        end
    end

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            rd_o[i] = mem_q[i].rd;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/rv_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered out-of-band results,
// with starvation-forced drain and a pending-destination mask for the hazard unit.
module rv_wb_arbiter
    import rv_wb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_pipe_data,
    input  logic [4:0]  i_pipe_rd,
    input  logic        i_pipe_reg_write,
    output logic        o_pipe_stall,
    input  logic        i_async_valid,
    input  logic [31:0] i_async_data,
    input  logic [4:0]  i_async_rd,
    output logic        o_async_ready,
    output logic [31:0] o_data,
    output logic [4:0]  o_rd,
    output logic        o_reg_write,
    output logic [31:0] o_pending_mask
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned StrvW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StrvW-1:0] StarveMax = StrvW'(STARVE_LIMIT);

    arb_state_e                 state_q, state_d;
    logic [StrvW-1:0]           starve_q, starve_d;
    logic                       reg_write_q, reg_write_d;
    logic [4:0]                 rd_q, rd_d;
    logic [31:0]                data_q, data_d;

    wb_entry_t                  push_entry, head;
    logic                       push, pop, pipe_live;
    logic                       fifo_full, fifo_empty;
    logic [CntW-1:0]            fifo_count, count_next;
    logic [FIFO_DEPTH-1:0]      fifo_valid;
    logic [FIFO_DEPTH-1:0][4:0] fifo_rd;

    assign pipe_live       = i_pipe_reg_write && (i_pipe_rd != 5'd0);
    assign push            = i_async_valid && !fifo_full;
    assign push_entry.data = i_async_data;
    assign push_entry.rd   = i_async_rd;

    rv_wb_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_reset_n),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .valid_o (fifo_valid),
        .rd_o    (fifo_rd)
    );

    always_comb begin
        pop          = 1'b0;
        o_pipe_stall = 1'b0;
        starve_d     = starve_q;
        reg_write_d  = 1'b0;
        rd_d         = rd_q;
        data_d       = data_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (pipe_live) begin
                    reg_write_d = 1'b1;
                    rd_d        = i_pipe_rd;
                    data_d      = i_pipe_data;
                end
            end
            ARB_WAIT: begin
                if (pipe_live) begin
                    reg_write_d = 1'b1;
                    rd_d        = i_pipe_rd;
                    data_d      = i_pipe_data;
                    if (starve_q < StarveMax) begin
                        starve_d = starve_q + StrvW'(1);
                    end
                end else begin
                    pop = !fifo_empty;
                end
            end
            ARB_FORCE: begin
                pop          = !fifo_empty;
                o_pipe_stall = pipe_live;
            end
            default: ;
        endcase

        // A head targeting x0 is retired silently.
        if (pop) begin
            starve_d = '0;
            if (head.rd != 5'd0) begin
                reg_write_d = 1'b1;
                rd_d        = head.rd;
                data_d      = head.data;
            end
        end

        count_next = fifo_count + CntW'(push) - CntW'(pop);
        if (count_next == CntW'(0)) begin
            state_d = ARB_IDLE;
        end else if (starve_d == StarveMax) begin
            state_d = ARB_FORCE;
        end else begin
            state_d = ARB_WAIT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= ARB_IDLE;
            starve_q    <= '0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        o_pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i]) begin
                o_pending_mask = o_pending_mask | rd_onehot(fifo_rd[i]);
            end
        end
    end

    assign o_async_ready = !fifo_full;
    assign o_reg_write   = reg_write_q;
    assign o_rd          = rd_q;
    assign o_data        = data_q;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Bench for rv_wb_arbiter: queue-based reference model checked every cycle, plus directed scenarios.
module tb_rv_wb_arbiter;

    localparam int unsigned Depth = 2;
    localparam int unsigned Limit = 4;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_pipe_data;
    logic [4:0]  i_pipe_rd;
    logic        i_pipe_reg_write;
    logic        o_pipe_stall;
    logic        i_async_valid;
    logic [31:0] i_async_data;
    logic [4:0]  i_async_rd;
    logic        o_async_ready;
    logic [31:0] o_data;
    logic [4:0]  o_rd;
    logic        o_reg_write;
    logic [31:0] o_pending_mask;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    rv_wb_arbiter #(
        .FIFO_DEPTH   (Depth),
        .STARVE_LIMIT (Limit)
    ) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_pipe_data      (i_pipe_data),
        .i_pipe_rd        (i_pipe_rd),
        .i_pipe_reg_write (i_pipe_reg_write),
        .o_pipe_stall     (o_pipe_stall),
        .i_async_valid    (i_async_valid),
        .i_async_data     (i_async_data),
        .i_async_rd       (i_async_rd),
        .o_async_ready    (o_async_ready),
        .o_data           (o_data),
        .o_rd             (o_rd),
        .o_reg_write      (o_reg_write),
        .o_pending_mask   (o_pending_mask)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, plus how long the head has been denied.
    typedef struct {
        logic [31:0] d;
        logic [4:0]  r;
    } ent_t;

    ent_t        mq[$];
    int          denied;
    bit          mvalid = 1'b0;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) begin
            if (mq[i].r != 5'd0) m[mq[i].r] = 1'b1;
        end
        return m;
    endfunction

    always @(negedge i_clk) begin
        ent_t e;
        bit   live, starved, take_fifo, push_ok;
        live    = i_pipe_reg_write && (i_pipe_rd != 5'd0);
        starved = (mq.size() > 0) && (denied == Limit);
        if (mvalid) begin
            check("m_stall", o_pipe_stall, starved && live);
            check("m_ready", o_async_ready, mq.size() < Depth);
            check("m_mask", o_pending_mask, model_mask());
            check("m_we", o_reg_write, exp_we);
            check("m_rd", o_rd, exp_rd);
            check("m_data", o_data, exp_data);
        end
        if (!i_reset_n) begin
            mq.delete();
            denied   = 0;
            exp_we   = 1'b0;
            exp_rd   = '0;
            exp_data = '0;
            mvalid   = 1'b1;
        end else if (mvalid) begin
            push_ok   = i_async_valid && (mq.size() < Depth);
            take_fifo = (mq.size() > 0) && (starved || !live);
            exp_we    = 1'b0;
            if (take_fifo) begin
                e      = mq.pop_front();
                denied = 0;
                if (e.r != 5'd0) begin
                    exp_we   = 1'b1;
                    exp_rd   = e.r;
                    exp_data = e.d;
                end
            end else begin
                if (live) begin
                    exp_we   = 1'b1;
                    exp_rd   = i_pipe_rd;
                    exp_data = i_pipe_data;
                end
                if (mq.size() > 0 && denied < Limit) denied++;
            end
            if (push_ok) begin
                e.d = i_async_data;
                e.r = i_async_rd;
                mq.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] rd, input logic [31:0] data);
        i_pipe_reg_write = we;
        i_pipe_rd        = rd;
        i_pipe_data      = data;
    endtask

    task automatic set_async(input logic v, input logic [4:0] rd, input logic [31:0] data);
        i_async_valid = v;
        i_async_rd    = rd;
        i_async_data  = data;
    endtask

    initial begin
        i_reset_n = 1'b0;
        set_pipe(1'b0, 5'd0, 32'h0);
        set_async(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        check("rst_we", o_reg_write, 1'b0);
        check("rst_rd", o_rd, 5'd0);
        check("rst_data", o_data, 32'h0);
        check("rst_ready", o_async_ready, 1'b1);
        check("rst_stall", o_pipe_stall, 1'b0);
        check("rst_mask", o_pending_mask, 32'h0);
        i_reset_n = 1'b1;
        tick();

        // Plain pipeline write
        set_pipe(1'b1, 5'd5, 32'h1234);
        tick();
        check("idle_we", o_reg_write, 1'b1);
        check("idle_rd", o_rd, 5'd5);
        check("idle_data", o_data, 32'h1234);
        check("idle_mask", o_pending_mask, 32'h0);
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();
        check("idle_we_off", o_reg_write, 1'b0);
        check("idle_rd_hold", o_rd, 5'd5);

        // Out-of-band result into an idle pipe
        set_async(1'b1, 5'd7, 32'hDEAD);
        tick();
        set_async(1'b0, 5'd0, 32'h0);
        check("async_mask", o_pending_mask, 32'h80);
        check("async_nobypass", o_reg_write, 1'b0);
        tick();
        check("async_we", o_reg_write, 1'b1);
        check("async_rd", o_rd, 5'd7);
        check("async_data", o_data, 32'hDEAD);
        check("async_mask_clr", o_pending_mask, 32'h0);
        tick();

        // Starvation with a live pipe every cycle
        set_async(1'b1, 5'd3, 32'h33);
        set_pipe(1'b1, 5'd10, 32'hA0);
        tick();
        set_async(1'b0, 5'd0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            set_pipe(1'b1, 5'(10 + k), 32'hA0 + k);
            tick();
            check("starve_rd", o_rd, 5'(10 + k));
            check("starve_stall", o_pipe_stall, (k == 4));
        end
        set_pipe(1'b1, 5'd15, 32'hAF);
        check("starve_stall_live", o_pipe_stall, 1'b1);
        tick();
        check("force_rd", o_rd, 5'd3);
        check("force_data", o_data, 32'h33);
        check("force_stall_off", o_pipe_stall, 1'b0);
        tick();
        check("held_rd", o_rd, 5'd15);
        check("held_data", o_data, 32'hAF);
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();

        // Full FIFO with a live pipe
        set_pipe(1'b1, 5'd20, 32'h200);
        set_async(1'b1, 5'd8, 32'h88);
        tick();
        check("full_ready1", o_async_ready, 1'b1);
        set_async(1'b1, 5'd9, 32'h99);
        set_pipe(1'b1, 5'd21, 32'h201);
        tick();
        check("full_ready0", o_async_ready, 1'b0);
        check("full_mask", o_pending_mask, 32'h300);
        set_async(1'b1, 5'd11, 32'hBB);
        for (int k = 2; k <= 4; k++) begin
            set_pipe(1'b1, 5'(20 + k), 32'h200 + k);
            tick();
            check("full_held", o_async_ready, 1'b0);
        end
        check("full_stall", o_pipe_stall, 1'b1);
        set_pipe(1'b1, 5'd25, 32'h205);
        tick();
        check("full_pop_rd", o_rd, 5'd8);
        check("full_pop_data", o_data, 32'h88);
        check("full_ready_back", o_async_ready, 1'b1);
        tick();
        set_async(1'b0, 5'd0, 32'h0);
        check("full_pipe_rd", o_rd, 5'd25);
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();
        check("drain_rd9", o_rd, 5'd9);
        tick();
        check("drain_rd11", o_rd, 5'd11);
        check("drain_data", o_data, 32'hBB);
        tick();

        // rd=0 on both paths
        set_async(1'b1, 5'd0, 32'h55);
        tick();
        set_async(1'b0, 5'd0, 32'h0);
        check("x0_mask", o_pending_mask, 32'h0);
        tick();
        check("x0_async_we", o_reg_write, 1'b0);
        check("x0_rd_hold", o_rd, 5'd11);
        set_pipe(1'b1, 5'd0, 32'h77);
        tick();
        check("x0_pipe_we", o_reg_write, 1'b0);
        check("x0_data_hold", o_data, 32'hBB);
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();

        // Reset with two entries pending
        set_pipe(1'b1, 5'd30, 32'h300);
        set_async(1'b1, 5'd12, 32'hC);
        tick();
        set_async(1'b1, 5'd13, 32'hD);
        set_pipe(1'b1, 5'd31, 32'h301);
        tick();
        set_async(1'b0, 5'd0, 32'h0);
        check("pre_rst_mask", o_pending_mask, 32'h3000);
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        set_pipe(1'b0, 5'd0, 32'h0);
        check("midrst_mask", o_pending_mask, 32'h0);
        check("midrst_ready", o_async_ready, 1'b1);
        check("midrst_we", o_reg_write, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("midrst_nowrite", o_reg_write, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
